// File: rtl/mem_responder_pkg.sv
// Shared types and default sizes for the mem_responder slice.
package mem_responder_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    IDLE     = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Byte store for mem_responder: one synchronous write port muxed between the
// boot loader and the request path, one synchronous read port.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              boot_sel,
  input  logic              boot_we,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_wdata,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_en   = boot_sel ? boot_we    : req_we;
    wr_addr = boot_sel ? boot_addr  : req_addr;
    wr_data = boot_sel ? boot_wdata : req_wdata;
  end

  // Contents survive reset on purpose: only the read register is cleared.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: boot-time byte loader followed by strobe-edge read/write
// service with a one-cycle ack. Optional MEM_RESPONDER_WRITE_PROTECT_EN.
//
// state    | meaning
// BOOT     | accepting boot bytes into mem from address 0
// IDLE     | booted, waiting for a rising strobe edge
// WAIT_LOW | request served, waiting for strobe to drop
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              boot_done,
  input  logic              req_strobe,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              fault
);

  state_e            state, state_nxt;
  logic              strobe_q;
  logic              req_edge;
  logic [ADDR_W-1:0] load_ptr;
  logic              boot_acc;
  logic              boot_end;
  logic              req_take;
  logic              req_we;
  logic              req_re;
  logic              wr_blocked;

  always_comb begin
    req_edge = req_strobe & ~strobe_q;
    boot_acc = (state == BOOT) & load_valid;
    boot_end = boot_acc & (load_last | (load_ptr == '1));
  end

  always_ff @(posedge clock) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:     if (boot_end)    state_nxt = IDLE;
      IDLE:     if (req_edge)    state_nxt = WAIT_LOW;
      WAIT_LOW: if (!req_strobe) state_nxt = IDLE;
      default:                   state_nxt = BOOT;
    endcase
  end

  always_comb begin
    load_ready = (state == BOOT);
    boot_done  = (state != BOOT);
    req_take   = (state == IDLE) & req_edge;
    req_we     = req_take & req_write & ~wr_blocked;
    req_re     = req_take & ~req_write;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_q <= 1'b0;
      load_ptr <= '0;
      ack      <= 1'b0;
    end else begin
      strobe_q <= req_strobe;
      ack      <= req_take;
      if (boot_acc) load_ptr <= load_ptr + 1'b1;
    end
  end

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
  // prog_len needs one extra bit so a full 256-byte image protects everything.
  logic [ADDR_W:0] prog_len;

  always_comb wr_blocked = ({1'b0, req_addr} < prog_len);

  always_ff @(posedge clock) begin
    if (reset) begin
      prog_len <= '0;
      fault    <= 1'b0;
    end else begin
      fault <= req_take & req_write & wr_blocked;
      if (boot_acc) prog_len <= {1'b0, load_ptr} + {{ADDR_W{1'b0}}, 1'b1};
    end
  end
`else
  always_comb begin
    wr_blocked = 1'b0;
    fault      = 1'b0;
  end
`endif

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock      (clock),
    .reset      (reset),
    .boot_sel   (state == BOOT),
    .boot_we    (boot_acc),
    .boot_addr  (load_ptr),
    .boot_wdata (load_data),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rd_en      (req_re),
    .rd_addr    (req_addr),
    .rd_data    (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed boot/request sequences, a
// vector table, and randomized requests against a behavioural memory model.
module tb_mem_responder;

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       boot_done;
  logic       req_strobe = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [7:0] rdata;
  logic       ack;
  logic       fault;

  always #5 clock = ~clock;

  mem_responder dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .boot_done  (boot_done),
    .req_strobe (req_strobe),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rdata      (rdata),
    .ack        (ack),
    .fault      (fault)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, boot progress, protected length, last read.
  logic [7:0] ref_mem [256];
  int         ref_ptr;
  int         ref_len;
  bit         ref_done;
  logic [7:0] last_rd;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    bit         exp_fault;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; req_strobe = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ref_ptr = 0; ref_len = 0; ref_done = 1'b0; last_rd = 8'h00;
  endtask

  task automatic boot_load(input logic [7:0] b[$], input bit use_last);
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clock);
      load_valid = 1'b1;
      load_data  = b[i];
      load_last  = use_last && (i == b.size() - 1);
      @(posedge clock);
      ref_mem[ref_ptr] = b[i];
      ref_ptr++;
      ref_len = ref_ptr;
      if (load_last || ref_ptr == 256) ref_done = 1'b1;
      #1;
      chk("boot_done_during_load", boot_done, ref_done);
    end
    @(negedge clock);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // One request: strobe high for one cycle, then low; returns what was seen.
  task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       output logic got_ack, output logic got_fault,
                       output logic [7:0] got_rd, output logic ack_after);
    @(negedge clock);
    req_write = wr; req_addr = a; req_wdata = d; req_strobe = 1'b1;
    @(negedge clock);
    got_ack = ack; got_fault = fault; got_rd = rdata;
    req_strobe = 1'b0;
    @(negedge clock);
    ack_after = ack;
  endtask

  // Request checked against the model, model updated afterwards.
  task automatic model_req(input string name, input bit wr, input logic [7:0] a,
                           input logic [7:0] d);
    logic ga, gf, ga2; logic [7:0] gr;
    bit blocked;
    blocked = PROT && wr && (int'(a) < ref_len);
    issue(wr, a, d, ga, gf, gr, ga2);
    if (!wr) last_rd = ref_mem[a];
    else if (!blocked) ref_mem[a] = d;
    chk({name, "_ack"}, ga, 1'b1);
    chk({name, "_fault"}, gf, blocked);
    chk({name, "_rdata"}, gr, last_rd);
    chk({name, "_ack_pulse"}, ga2, 1'b0);
  endtask

  initial begin
    vec_t       tbl[8];
    logic [7:0] q[$];
    logic       ga, gf, ga2;
    logic [7:0] gr;
    int         acks;

    tbl[0] = '{1'b1, 8'h80, 8'hA5, 8'h33, 1'b0};
    tbl[1] = '{1'b0, 8'h80, 8'h00, 8'hA5, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 8'h00, 8'h11, 1'b0};
    tbl[3] = '{1'b1, 8'h03, 8'h5A, 8'h11, 1'b0};
    tbl[4] = '{1'b0, 8'h03, 8'h00, 8'h5A, 1'b0};
    tbl[5] = '{1'b1, 8'h01, 8'hEE, 8'h5A, PROT};
    tbl[6] = '{1'b0, 8'h01, 8'h00, PROT ? 8'h22 : 8'hEE, 1'b0};
    tbl[7] = '{1'b0, 8'h02, 8'h00, 8'h33, 1'b0};

    do_reset();
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_ack", ack, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_boot_done", boot_done, 1'b0);
    chk("rst_load_ready", load_ready, 1'b1);

    // Strobe edges during BOOT are ignored.
    @(negedge clock);
    req_write = 1'b0; req_addr = 8'h02; req_strobe = 1'b1;
    @(negedge clock);
    chk("boot_strobe_ack", ack, 1'b0);
    req_strobe = 1'b0;
    @(negedge clock);
    chk("boot_strobe_ack2", ack, 1'b0);
    chk("boot_strobe_rdata", rdata, 8'h00);

    q = '{8'h11, 8'h22, 8'h33};
    boot_load(q, 1'b1);
    chk("boot3_done", boot_done, 1'b1);
    chk("boot3_load_ready", load_ready, 1'b0);
    model_req("boot3_read2", 1'b0, 8'h02, 8'h00);

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].wr, tbl[i].addr, tbl[i].wdata, ga, gf, gr, ga2);
      chk($sformatf("tbl%0d_ack", i), ga, 1'b1);
      chk($sformatf("tbl%0d_fault", i), gf, tbl[i].exp_fault);
      chk($sformatf("tbl%0d_rdata", i), gr, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_ack_pulse", i), ga2, 1'b0);
      if (tbl[i].wr && !tbl[i].exp_fault) ref_mem[tbl[i].addr] = tbl[i].wdata;
      if (!tbl[i].wr) last_rd = tbl[i].exp_rd;
    end

    // Boot bytes after boot_done must not land in memory.
    @(negedge clock);
    load_valid = 1'b1; load_data = 8'h99;
    @(negedge clock);
    load_valid = 1'b0;
    model_req("post_boot_load_ignored", 1'b0, 8'h03, 8'h00);

    // Strobe held high for 5 cycles gives exactly one ack.
    @(negedge clock);
    req_write = 1'b0; req_addr = 8'h01; req_strobe = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clock);
      if (ack) acks++;
    end
    chk("held_strobe_acks", acks, 1);
    chk("held_strobe_rdata", rdata, ref_mem[1]);
    last_rd = ref_mem[1];
    req_strobe = 1'b0;
    @(negedge clock);
    chk("held_strobe_no_ack", ack, 1'b0);
    model_req("after_held_read0", 1'b0, 8'h00, 8'h00);

    // Full 256-byte boot without load_last.
    do_reset();
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom_range(0, 255)));
    boot_load(q, 1'b0);
    chk("boot256_done", boot_done, 1'b1);
    model_req("boot256_wr10", 1'b1, 8'h10, 8'hFF);
    model_req("boot256_rd10", 1'b0, 8'h10, 8'h00);
    model_req("boot256_rdff", 1'b0, 8'hFF, 8'h00);

    // Reset in the middle of boot restarts loading at address 0.
    do_reset();
    q = '{8'h01, 8'h02};
    boot_load(q, 1'b0);
    chk("midboot_not_done", boot_done, 1'b0);
    do_reset();
    q = '{8'h7E};
    boot_load(q, 1'b1);
    chk("midboot_len", ref_len, 1);
    model_req("midboot_rd0", 1'b0, 8'h00, 8'h00);
    model_req("midboot_rd1_kept", 1'b0, 8'h01, 8'h00);
    model_req("midboot_wr0", 1'b1, 8'h00, 8'hC3);
    model_req("midboot_wr1", 1'b1, 8'h01, 8'h3C);
    model_req("midboot_rd0b", 1'b0, 8'h00, 8'h00);
    model_req("midboot_rd1b", 1'b0, 8'h01, 8'h00);

    for (int i = 0; i < 200; i++) begin
      model_req($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the control unit's byte-wide memory bus. It owns a 256×8 program/data store and completes the control unit's strobe-qualified read and write requests with a one-cycle acknowledge. After reset it runs a boot phase, accepting a byte stream that fills memory from address 0. Only after the boot phase ends does it release the control unit through `boot_done`. In hardware it replaces the bench-side program loader.

## Interface

Parameters:
- `ADDR_W`, 8, address width.
- `DATA_W`, 8, data width.
- `DEPTH`, 256, number of words; must equal 2**ADDR_W.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  boot byte present.
- `load_data`  in  DATA_W  boot byte.
- `load_last`  in  1  marks the final boot byte.
- `load_ready`  out  1  responder accepts boot bytes.
- `boot_done`  out  1  boot finished; control unit may run.
- `req_strobe`  in  1  control unit memory clock; a rising edge starts a request.
- `req_write`  in  1  1 = write, 0 = read; sampled on the strobe edge.
- `req_addr`  in  ADDR_W  request address.
- `req_wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  read data, held until the next read.
- `ack`  out  1  one-cycle pulse for each completed request.
- `fault`  out  1  one-cycle pulse for a rejected write; present only with the write-protect macro.

## Operation

- States:
  - BOOT: reset state.
  - IDLE.
  - WAIT_LOW.
- Edge detect:
  - `strobe_q` registers `req_strobe` every cycle, in all states.
  - A request is `req_strobe & ~strobe_q`.
- BOOT:
  - `load_ready` = 1.
  - Each cycle with `load_valid` writes `load_data` to `mem[load_ptr]`, then increments `load_ptr`.
  - Go to IDLE and set `boot_done` on either of:
    - an accepted byte with `load_last`;
    - an accepted byte at `load_ptr` = 255.
  - `prog_len` = number of bytes accepted, 1..256, stored in ADDR_W+1 bits.
  - Strobe edges in BOOT are ignored and never acknowledged.
- IDLE, on a request:
  - Write: `mem[req_addr] <= req_wdata`.
  - Read: `rdata <= mem[req_addr]`.
  - `ack` asserts for the next cycle.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - Return to IDLE once `req_strobe` is sampled 0.
  - A strobe held high therefore produces exactly one request.
- After `boot_done`:
  - `load_ready` = 0.
  - `load_valid` is ignored.
- Reset values:
  - `rdata` = 0, `ack` = 0, `fault` = 0.
  - `boot_done` = 0, `load_ready` = 1.
  - `load_ptr` = 0, `prog_len` = 0, `strobe_q` = 0.
- Memory contents are not cleared by reset. Reset mid-boot restarts loading at address 0.
- Reset during WAIT_LOW returns to BOOT. No `ack` is issued for the interrupted request.

## Timing

- Request edge sampled at clock edge N:
  - Write lands in the array at N.
  - `rdata` is valid after N.
  - `ack` is high from N to N+1.
- Read latency is 1 cycle.
- Read-after-write to the same address, on the next request, returns the new data.
- Minimum request spacing is 2 cycles: strobe high, then strobe low.
- Boot throughput is 1 byte/cycle. `boot_done` rises at the edge that accepts the final byte.

## Configuration

- `MEM_RESPONDER_WRITE_PROTECT_EN` defined:
  - After boot, writes with `req_addr < prog_len` are dropped.
  - `ack` still pulses for the dropped write.
  - `fault` pulses in the same cycle as that `ack`.
  - Reads are unaffected.
- Undefined:
  - All writes are performed.
  - `fault` is tied to 0.
  - `prog_len` logic is removed.

## Structure

- Package `mem_responder_pkg` holds:
  - the state enum (BOOT, IDLE, WAIT_LOW);
  - the ADDR_W/DATA_W/DEPTH defaults.
- Sub-module `mem_array`:
  - DEPTH×DATA_W array with one synchronous write port and one synchronous read port.
  - Write-port mux: boot path during BOOT, request path otherwise.
- The top level holds the FSM, edge detect, `load_ptr`/`prog_len` and the protect compare.

## Test plan

- Boot load: load bytes 0x11, 0x22, 0x33, with `load_last` on 0x33.
  - `boot_done` rises at the third accept.
  - A read of address 2 returns 0x33 with `ack` one cycle after the strobe edge.
- Strobe ignored in boot: pulse `req_strobe` while in BOOT.
  - No `ack`.
  - `rdata` stays 0x00.
- Write then read: write 0xA5 to 0x80, then read 0x80.
  - Two `ack` pulses.
  - `rdata` = 0xA5.
- Strobe held high for 5 cycles with a read of 0x01:
  - Exactly one `ack`.
  - A second request is accepted only after strobe drops.
- Boot wrap and protect: load 256 bytes without `load_last`.
  - `boot_done` rises at the 256th byte.
  - With `MEM_RESPONDER_WRITE_PROTECT_EN`, a write of 0xFF to 0x10 gives `ack` plus `fault`, and a later read of 0x10 returns the original byte.
- Reset mid-boot: load 0x01 and 0x02, assert `reset`, then load 0x7E with `load_last`.
  - A read of address 0 returns 0x7E.
  - `prog_len` = 1.
